// File: rtl/wb_commit_buffer.sv
// Write-side buffer in front of the 32x32 register file: queues stage-4 results, issues one
// regfile write per cycle, and forwards still-pending values to the two read addresses.
module wb_commit_buffer #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 5,
    parameter int unsigned DW    = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [AW-1:0]            in_add,
    input  logic [DW-1:0]            in_data,
    input  logic                     wb_stall,
    output logic [AW-1:0]            write_add,
    output logic [DW-1:0]            z5_output,
    output logic                     write_enable,
    input  logic [AW-1:0]            r1_add,
    input  logic [AW-1:0]            r2_add,
    output logic                     r1_fwd_hit,
    output logic [DW-1:0]            r1_fwd_value,
    output logic                     r2_fwd_hit,
    output logic [DW-1:0]            r2_fwd_value,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     idle
);

    localparam int unsigned PW = $clog2(DEPTH);

    logic [AW-1:0] addr_q [DEPTH];
    logic [AW-1:0] addr_d [DEPTH];
    logic [DW-1:0] data_q [DEPTH];
    logic [DW-1:0] data_d [DEPTH];
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW:0]   count_q, count_d;
    logic          we_q, we_d;
    logic [AW-1:0] wa_q, wa_d;
    logic [DW-1:0] z5_q, z5_d;
    logic          push, pop;
    logic [PW-1:0] fwd_idx;

    assign in_ready     = (count_q != (PW+1)'(DEPTH));
    assign write_add    = wa_q;
    assign z5_output    = z5_q;
    assign write_enable = we_q;
    assign count        = count_q;
    assign idle         = (count_q == '0) && !we_q;

    always_comb begin
        push     = in_valid && in_ready;
        pop      = !wb_stall && (count_q != '0);
        addr_d   = addr_q;
        data_d   = data_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        we_d     = we_q;
        wa_d     = wa_q;
        z5_d     = z5_q;

        if (push) begin
            addr_d[wr_ptr_q] = in_add;
            data_d[wr_ptr_q] = in_data;
            wr_ptr_d         = wr_ptr_q + PW'(1);
        end

        // Output stage only moves when the regfile port is free; otherwise everything holds.
        if (pop) begin
            wa_d     = addr_q[rd_ptr_q];
            z5_d     = data_q[rd_ptr_q];
            we_d     = 1'b1;
            rd_ptr_d = rd_ptr_q + PW'(1);
        end else if (!wb_stall) begin
            we_d = 1'b0;
        end

        unique case ({push, pop})
            2'b10:   count_d = count_q + (PW+1)'(1);
            2'b01:   count_d = count_q - (PW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // Scan oldest to newest so the youngest matching entry overwrites earlier hits.
    always_comb begin
        fwd_idx      = '0;
        r1_fwd_hit   = we_q && (wa_q == r1_add);
        r1_fwd_value = r1_fwd_hit ? z5_q : '0;
        r2_fwd_hit   = we_q && (wa_q == r2_add);
        r2_fwd_value = r2_fwd_hit ? z5_q : '0;
        for (int k = 0; k < DEPTH; k++) begin
            fwd_idx = rd_ptr_q + PW'(k);
            if ((PW+1)'(k) < count_q) begin
                if (addr_q[fwd_idx] == r1_add) begin
                    r1_fwd_hit   = 1'b1;
                    r1_fwd_value = data_q[fwd_idx];
                end
                if (addr_q[fwd_idx] == r2_add) begin
                    r2_fwd_hit   = 1'b1;
                    r2_fwd_value = data_q[fwd_idx];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_q[i] <= '0;
                data_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            we_q     <= 1'b0;
            wa_q     <= '0;
            z5_q     <= '0;
        end else begin
            addr_q   <= addr_d;
            data_q   <= data_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            we_q     <= we_d;
            wa_q     <= wa_d;
            z5_q     <= z5_d;
        end
    end

endmodule

// File: tb/tb_wb_commit_buffer.sv
// Directed self-checking bench for wb_commit_buffer (DEPTH=4, AW=5, DW=32).
module tb_wb_commit_buffer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_add;
    logic [31:0] in_data;
    logic        wb_stall;
    logic [4:0]  write_add;
    logic [31:0] z5_output;
    logic        write_enable;
    logic [4:0]  r1_add;
    logic [4:0]  r2_add;
    logic        r1_fwd_hit;
    logic [31:0] r1_fwd_value;
    logic        r2_fwd_hit;
    logic [31:0] r2_fwd_value;
    logic [2:0]  count;
    logic        idle;

    int n_cmp = 0;
    int n_err = 0;

    wb_commit_buffer #(
        .DEPTH (4),
        .AW    (5),
        .DW    (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_add       (in_add),
        .in_data      (in_data),
        .wb_stall     (wb_stall),
        .write_add    (write_add),
        .z5_output    (z5_output),
        .write_enable (write_enable),
        .r1_add       (r1_add),
        .r2_add       (r2_add),
        .r1_fwd_hit   (r1_fwd_hit),
        .r1_fwd_value (r1_fwd_value),
        .r2_fwd_hit   (r2_fwd_hit),
        .r2_fwd_value (r2_fwd_value),
        .count        (count),
        .idle         (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_add   = '0;
        in_data  = '0;
        wb_stall = 1'b0;
        r1_add   = 5'd31;
        r2_add   = 5'd30;
        step();
        step();
        chk("rst_count", count, 0);
        chk("rst_we", write_enable, 0);
        chk("rst_wa", write_add, 0);
        chk("rst_z5", z5_output, 0);
        chk("rst_idle", idle, 1);
        chk("rst_ready", in_ready, 1);
        reset = 1'b0;

        // Single write: visible one edge after the push edge.
        in_valid = 1'b1; in_add = 5'd3; in_data = 32'hA5;
        step();
        chk("single_cnt1", count, 1);
        chk("single_we0", write_enable, 0);
        in_valid = 1'b0;
        step();
        chk("single_we", write_enable, 1);
        chk("single_wa", write_add, 3);
        chk("single_z5", z5_output, 32'hA5);
        chk("single_cnt0", count, 0);
        chk("single_busy", idle, 0);
        step();
        chk("single_we_off", write_enable, 0);
        chk("single_idle", idle, 1);
        chk("single_wa_hold", write_add, 3);

        // Fill under stall, fifth push dropped, then drain in order.
        wb_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            in_valid = 1'b1; in_add = 5'(i + 1); in_data = 32'h100 + 32'(i);
            step();
        end
        chk("fill_cnt", count, 4);
        chk("fill_ready", in_ready, 0);
        in_add = 5'd5; in_data = 32'h104;
        step();
        chk("fill_drop_cnt", count, 4);
        chk("fill_stall_we", write_enable, 0);
        in_valid = 1'b0; wb_stall = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("drain_we", write_enable, 1);
            chk("drain_wa", write_add, 64'(i + 1));
            chk("drain_z5", z5_output, 64'h100 + 64'(i));
            chk("drain_cnt", count, 64'(3 - i));
        end
        step();
        chk("drain_done_we", write_enable, 0);
        chk("drain_idle", idle, 1);

        // Forwarding: output stage {7,33}, FIFO {7,11},{7,22}.
        in_valid = 1'b1; in_add = 5'd7; in_data = 32'h33;
        step();
        in_data = 32'h11;
        step();
        wb_stall = 1'b1; in_data = 32'h22;
        step();
        in_valid = 1'b0; r1_add = 5'd7; r2_add = 5'd9;
        #1;
        chk("fwd_cnt", count, 2);
        chk("fwd_we", write_enable, 1);
        chk("fwd_r1_hit", r1_fwd_hit, 1);
        chk("fwd_r1_val", r1_fwd_value, 32'h22);
        chk("fwd_r2_hit", r2_fwd_hit, 0);
        chk("fwd_r2_val", r2_fwd_value, 0);
        in_valid = 1'b1; in_add = 5'd9; in_data = 32'h99;
        #1;
        chk("fwd_no_incoming_hit", r2_fwd_hit, 0);
        chk("fwd_no_incoming_val", r2_fwd_value, 0);
        in_valid = 1'b0; wb_stall = 1'b0;
        step();
        chk("fwd_d1_z5", z5_output, 32'h11);
        chk("fwd_d1_val", r1_fwd_value, 32'h22);
        step();
        chk("fwd_d2_z5", z5_output, 32'h22);
        chk("fwd_d2_hit", r1_fwd_hit, 1);
        chk("fwd_d2_val", r1_fwd_value, 32'h22);
        step();
        chk("fwd_d3_hit", r1_fwd_hit, 0);
        chk("fwd_d3_val", r1_fwd_value, 0);

        // Stall hold while {4,44} is on the write port, {5,55} queued behind it.
        in_valid = 1'b1; in_add = 5'd4; in_data = 32'h44;
        step();
        in_add = 5'd5; in_data = 32'h55;
        step();
        in_valid = 1'b0; wb_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("hold_we", write_enable, 1);
            chk("hold_wa", write_add, 4);
            chk("hold_z5", z5_output, 32'h44);
            chk("hold_cnt", count, 1);
        end
        wb_stall = 1'b0;
        step();
        chk("hold_next_wa", write_add, 5);
        chk("hold_next_z5", z5_output, 32'h55);
        step();
        chk("hold_done_we", write_enable, 0);

        // Sustained push+pop at count=3 across pointer wrap: 10 back-to-back pushes.
        wb_stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; in_add = 5'(10 + k); in_data = 32'h200 + 32'(k);
            step();
        end
        chk("wrap_cnt3", count, 3);
        wb_stall = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            in_add = 5'(12 + j); in_data = 32'h202 + 32'(j);
            step();
            chk("wrap_cnt", count, 3);
            chk("wrap_we", write_enable, 1);
            chk("wrap_wa", write_add, 64'(9 + j));
            chk("wrap_z5", z5_output, 64'h1FF + 64'(j));
        end
        in_valid = 1'b0;
        for (int j = 7; j <= 9; j++) begin
            step();
            chk("wrap_tail_z5", z5_output, 64'h200 + 64'(j));
            chk("wrap_tail_cnt", count, 64'(9 - j));
        end
        step();
        chk("wrap_done_we", write_enable, 0);

        // Reset with count=3 and a write in flight.
        in_valid = 1'b1; in_add = 5'd20; in_data = 32'h300;
        step();
        in_add = 5'd21; in_data = 32'h301;
        step();
        wb_stall = 1'b1; in_add = 5'd22; in_data = 32'h302;
        step();
        in_add = 5'd23; in_data = 32'h303;
        step();
        in_valid = 1'b0; r1_add = 5'd20; r2_add = 5'd23;
        #1;
        chk("prerst_cnt", count, 3);
        chk("prerst_we", write_enable, 1);
        chk("prerst_r1_val", r1_fwd_value, 32'h300);
        chk("prerst_r2_val", r2_fwd_value, 32'h303);
        reset = 1'b1; wb_stall = 1'b0;
        step();
        chk("midrst_cnt", count, 0);
        chk("midrst_we", write_enable, 0);
        chk("midrst_wa", write_add, 0);
        chk("midrst_z5", z5_output, 0);
        chk("midrst_idle", idle, 1);
        chk("midrst_r1_hit", r1_fwd_hit, 0);
        chk("midrst_r2_hit", r2_fwd_hit, 0);
        reset = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("postrst_we", write_enable, 0);
            chk("postrst_cnt", count, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
